// File: rtl/up_core_pkg.sv
// up_core_pkg: opcode map, phase encodings and instruction-class helpers for up_acc_core.
package up_core_pkg;
  localparam logic [3:0] OP_JC    = 4'd0;
  localparam logic [3:0] OP_JNC   = 4'd1;
  localparam logic [3:0] OP_CMPI  = 4'd2;
  localparam logic [3:0] OP_CMPM  = 4'd3;
  localparam logic [3:0] OP_LIT   = 4'd4;
  localparam logic [3:0] OP_IN    = 4'd5;
  localparam logic [3:0] OP_LD    = 4'd6;
  localparam logic [3:0] OP_ST    = 4'd7;
  localparam logic [3:0] OP_JZ    = 4'd8;
  localparam logic [3:0] OP_JNZ   = 4'd9;
  localparam logic [3:0] OP_ADDI  = 4'd10;
  localparam logic [3:0] OP_ADDM  = 4'd11;
  localparam logic [3:0] OP_JMP   = 4'd12;
  localparam logic [3:0] OP_OUT   = 4'd13;
  localparam logic [3:0] OP_NANDI = 4'd14;
  localparam logic [3:0] OP_NANDM = 4'd15;
  localparam logic PH_FETCH = 1'b0;
  localparam logic PH_EXEC  = 1'b1;
  function automatic logic is_mem_op(input logic [3:0] op);
    return op inside {OP_CMPM, OP_LD, OP_ST, OP_ADDM, OP_NANDM};
  endfunction
  function automatic logic is_two_word(input logic [3:0] op);
    return is_mem_op(op) || (op inside {OP_JC, OP_JNC, OP_JZ, OP_JNZ, OP_JMP});
  endfunction
endpackage

// File: rtl/up_alu.sv
// up_alu: combinational ADD / CMP / NAND unit with per-op write enables for accu and flags.
module up_alu
  import up_core_pkg::*;
#(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic [3:0]        opcode,
  output logic [DATA_W-1:0] result,
  output logic              c_out,
  output logic              z_out,
  output logic              c_we,
  output logic              z_we,
  output logic              acc_we
);
  logic [DATA_W:0] sum;
  logic add, cmp, nd;
  always_comb begin
    sum    = {1'b0, a} + {1'b0, b};
    add    = opcode inside {OP_ADDI, OP_ADDM};
    cmp    = opcode inside {OP_CMPI, OP_CMPM};
    nd     = opcode inside {OP_NANDI, OP_NANDM};
    result = add ? sum[DATA_W-1:0] : ~(a & b);
    c_out  = add ? sum[DATA_W] : (a >= b);
    z_out  = cmp ? (a == b) : (result == '0);
    c_we   = add | cmp;
    z_we   = add | cmp | nd;
    acc_we = add | nd;
  end
endmodule

// File: rtl/up_acc_core.sv
// up_acc_core: two-phase accumulator uP core; define UP_CORE_WAIT_EN to add mem_ready wait states on memory ops.
module up_acc_core
  import up_core_pkg::*;
#(
  parameter int DATA_W = 4,
  parameter int ADDR_W = 12,
  parameter int OP_W   = 4
) (
  input  logic                   clock,
  input  logic                   reset,
`ifdef UP_CORE_WAIT_EN
  input  logic                   mem_ready,
`endif
  input  logic [OP_W+DATA_W-1:0] program_word,
  output logic [ADDR_W-1:0]      pc,
  output logic                   phase,
  output logic [OP_W-1:0]        instr,
  output logic [DATA_W-1:0]      oprnd,
  output logic [DATA_W-1:0]      accu,
  output logic                   c_flag,
  output logic                   z_flag,
  output logic [DATA_W-1:0]      data_bus,
  output logic [ADDR_W-1:0]      ram_addr,
  output logic [DATA_W-1:0]      ram_wdata,
  output logic                   ram_we,
  input  logic [DATA_W-1:0]      ram_rdata,
  input  logic [DATA_W-1:0]      pushbuttons,
  output logic [DATA_W-1:0]      out_port
);
  logic [2*DATA_W+OP_W-1:0] wide;
  logic [ADDR_W-1:0] target, pc_inc;
  logic [DATA_W-1:0] op_b, alu_res;
  logic exec, two_word, mem_op, taken, stall;
  logic alu_c, alu_z, c_we, z_we, acc_we;
  up_alu #(.DATA_W(DATA_W)) u_alu (
    .a(accu), .b(op_b), .opcode(instr), .result(alu_res),
    .c_out(alu_c), .z_out(alu_z), .c_we(c_we), .z_we(z_we), .acc_we(acc_we)
  );
  // The second word of a two-word op is read at the already-incremented pc.
  assign wide      = {oprnd, program_word};
  assign target    = wide[ADDR_W-1:0];
  assign pc_inc    = pc + ADDR_W'(1);
  assign exec      = phase == PH_EXEC;
  assign two_word  = is_two_word(instr);
  assign mem_op    = is_mem_op(instr);
  assign op_b      = mem_op ? ram_rdata : oprnd;
  assign ram_addr  = (exec && mem_op) ? target : '0;
  assign ram_wdata = accu;
  assign ram_we    = exec && instr == OP_ST;
`ifdef UP_CORE_WAIT_EN
  assign stall = exec && mem_op && !mem_ready;
`else
  assign stall = 1'b0;
`endif
  always_comb begin
    taken = (instr == OP_JC && c_flag) || (instr == OP_JNC && !c_flag) ||
            (instr == OP_JZ && z_flag) || (instr == OP_JNZ && !z_flag) || instr == OP_JMP;
    data_bus = !exec ? '0 :
               mem_op ? (instr == OP_ST ? accu : ram_rdata) :
               instr == OP_IN ? pushbuttons :
               instr == OP_OUT ? accu :
               two_word ? '0 : oprnd;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      pc       <= '0;
      phase    <= PH_FETCH;
      instr    <= '0;
      oprnd    <= '0;
      accu     <= '0;
      c_flag   <= 1'b0;
      z_flag   <= 1'b0;
      out_port <= '0;
    end else if (!exec) begin
      {instr, oprnd} <= program_word;
      pc             <= pc_inc;
      phase          <= PH_EXEC;
    end else if (!stall) begin
      phase    <= PH_FETCH;
      pc       <= (two_word && taken) ? target : two_word ? pc_inc : pc;
      accu     <= acc_we ? alu_res :
                  instr == OP_LIT ? oprnd :
                  instr == OP_IN ? pushbuttons :
                  instr == OP_LD ? ram_rdata : accu;
      c_flag   <= c_we ? alu_c : c_flag;
      z_flag   <= z_we ? alu_z : z_flag;
      out_port <= instr == OP_OUT ? accu : out_port;
    end
  end
endmodule

// File: tb/tb_up_acc_core.sv
// tb_up_acc_core: directed scoreboard bench for up_acc_core (DATA_W=4, ADDR_W=12).
module tb_up_acc_core;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  program_word;
  logic [11:0] pc, ram_addr;
  logic        phase, c_flag, z_flag, ram_we;
  logic [3:0]  instr, oprnd, accu, data_bus, ram_wdata, ram_rdata, out_port;
  logic [3:0]  pushbuttons = 4'h0;
  logic [7:0]  rom [0:4095];
  logic [3:0]  ram [0:4095];
`ifdef UP_CORE_WAIT_EN
  logic        mem_ready = 1'b1;
`endif
  typedef struct { string tag; logic [31:0] v; } exp_t;
  exp_t sbq[$];
  int n_chk = 0;
  int n_fail = 0;

  up_acc_core #(.DATA_W(4), .ADDR_W(12), .OP_W(4)) dut (
    .clock(clock), .reset(reset),
`ifdef UP_CORE_WAIT_EN
    .mem_ready(mem_ready),
`endif
    .program_word(program_word), .pc(pc), .phase(phase), .instr(instr),
    .oprnd(oprnd), .accu(accu), .c_flag(c_flag), .z_flag(z_flag),
    .data_bus(data_bus), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_we(ram_we), .ram_rdata(ram_rdata), .pushbuttons(pushbuttons),
    .out_port(out_port)
  );

  always #5 clock = ~clock;
  assign program_word = rom[pc];
  assign ram_rdata    = ram[ram_addr];
  always @(posedge clock) if (ram_we) ram[ram_addr] <= ram_wdata;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic push(input string t, input logic [31:0] v);
    sbq.push_back('{t, v});
  endtask

  task automatic pop(input logic [31:0] obs);
    exp_t e;
    n_chk++;
    if (sbq.size() == 0) begin
      n_fail++;
      $error("FAIL sb_underflow: observed %0h with no expected entry", obs);
    end else begin
      e = sbq.pop_front();
      assert (obs === e.v) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.v);
      end
    end
  endtask

  task automatic load(input logic [7:0] prog [8]);
    for (int i = 0; i < 4096; i++) begin
      rom[i] = 8'h44;
      ram[i] = 4'h0;
    end
    for (int i = 0; i < 8; i++) rom[i] = prog[i];
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
  endtask

  initial begin
    logic [7:0] p [8];
    // LIT 9, ADDI 8, OUT, LIT 4 -- then reset during the LIT 4 execute
    p = '{8'h49, 8'hA8, 8'hD0, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
    load(p);
    push("rst_pc", 0); push("rst_phase", 0);
    push("add_accu", 1); push("add_c", 1); push("add_z", 0); push("add_pc", 2);
    push("out1", 1); push("mid_exec_phase", 1);
    push("r_pc", 0); push("r_phase", 0); push("r_instr", 0); push("r_oprnd", 0);
    push("r_accu", 0); push("r_c", 0); push("r_z", 0); push("r_out", 0); push("r_we", 0);
    do_reset();
    pop(32'(pc)); pop(32'(phase));
    tick(4);
    pop(32'(accu)); pop(32'(c_flag)); pop(32'(z_flag)); pop(32'(pc));
    tick(2);
    pop(32'(out_port));
    tick(1);
    pop(32'(phase));
    reset = 1'b1;
    tick(1);
    reset = 1'b0;
    pop(32'(pc)); pop(32'(phase)); pop(32'(instr)); pop(32'(oprnd));
    pop(32'(accu)); pop(32'(c_flag)); pop(32'(z_flag)); pop(32'(out_port)); pop(32'(ram_we));

    // LIT 5, CMPI 5, JZ 0x123: taken
    p = '{8'h45, 8'h25, 8'h81, 8'h23, 8'h44, 8'h44, 8'h44, 8'h44};
    load(p);
    push("cmpeq_c", 1); push("cmpeq_z", 1); push("jz_bus", 0); push("jz_pc", 12'h123);
    do_reset();
    tick(4);
    pop(32'(c_flag)); pop(32'(z_flag));
    tick(1);
    pop(32'(data_bus));
    tick(1);
    pop(32'(pc));

    // LIT 5, CMPI 6, JZ 0x123: not taken
    p = '{8'h45, 8'h26, 8'h81, 8'h23, 8'h44, 8'h44, 8'h44, 8'h44};
    load(p);
    push("cmplt_c", 0); push("cmplt_z", 0); push("jz_nt_pc", 4); push("next_fetch_pc", 5);
    do_reset();
    tick(4);
    pop(32'(c_flag)); pop(32'(z_flag));
    tick(2);
    pop(32'(pc));
    tick(1);
    pop(32'(pc));

    // LIT A, ST 0x010, LIT 0, LD 0x010
    p = '{8'h4A, 8'h70, 8'h10, 8'h40, 8'h60, 8'h10, 8'h44, 8'h44};
    load(p);
    push("fetch_addr", 0); push("st_we", 1); push("st_addr", 12'h010); push("st_wdata", 4'hA);
    push("st_we_off", 0); push("lit0", 0); push("ld_bus", 4'hA); push("ld_accu", 4'hA);
    do_reset();
    tick(2);
    pop(32'(ram_addr));
    tick(1);
    pop(32'(ram_we)); pop(32'(ram_addr)); pop(32'(ram_wdata));
    tick(1);
    pop(32'(ram_we));
    tick(2);
    pop(32'(accu));
    tick(1);
    pop(32'(data_bus));
    tick(1);
    pop(32'(accu));

    // IN, NANDI F, OUT with pushbuttons = 3
    p = '{8'h50, 8'hEF, 8'hD0, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
    load(p);
    pushbuttons = 4'h3;
    push("in_bus", 3); push("fetch_bus", 0); push("nand_accu", 4'hC); push("nand_z", 0);
    push("out_port", 4'hC);
    do_reset();
    tick(1);
    pop(32'(data_bus));
    tick(1);
    pop(32'(data_bus));
    tick(2);
    pop(32'(accu)); pop(32'(z_flag));
    tick(2);
    pop(32'(out_port));

    // JMP 0xFFF, LIT 7 there: pc wraps
    p = '{8'hCF, 8'hFF, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
    load(p);
    rom[4095] = 8'h47;
    push("jmp_pc", 12'hFFF); push("wrap_pc", 0); push("wrap_accu", 7);
    do_reset();
    tick(2);
    pop(32'(pc));
    tick(1);
    pop(32'(pc));
    tick(1);
    pop(32'(accu));

`ifdef UP_CORE_WAIT_EN
    // LD 0x010 with mem_ready low for 3 execute cycles
    p = '{8'h60, 8'h10, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44, 8'h44};
    load(p);
    ram[16] = 4'h5;
    mem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      push("wait_phase", 1); push("wait_accu", 0); push("wait_addr", 12'h010);
    end
    push("ready_accu", 5); push("ready_phase", 0); push("ready_pc", 2);
    do_reset();
    for (int i = 0; i < 4; i++) begin
      tick(1);
      pop(32'(phase)); pop(32'(accu)); pop(32'(ram_addr));
    end
    mem_ready = 1'b1;
    tick(1);
    pop(32'(accu)); pop(32'(phase)); pop(32'(pc));
`endif

    if (sbq.size() != 0) begin
      n_chk++;
      n_fail++;
      $error("FAIL sb_leftover: observed %0d unchecked entries expected 0", sbq.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
